ram_word_accumulator: RTL and testbench
=======================================

// Module: ram_word_accumulator
// PURPOSE
//  Read-side consumer of the 64 x 512-bit word RAM. On start, it sequences the RAM read
//  address over a run of words and splits each word into 16 unsigned 32-bit lanes. It sums
//  the lanes with a parallel adder tree and accumulates the tree outputs into one total.
//  It drives the RAM read address and consumes RAM data_out. It never writes the RAM; the
//  write_enable handling stays with the loader.
// PARAMETERS
//  DATA_W  512            RAM word width
//  ADDR_W  6              RAM address width (depth 2**ADDR_W = 64)
//  LANE_W  32             width of one unsigned lane
//  LANES   DATA_W/LANE_W  lanes per word (16)
//  ACC_W   48             accumulator width
// PORTS
//  clk         in   1        single clock; all state updates on posedge
//  rst_n       in   1        synchronous reset, active-low
//  start       in   1        start a run; sampled only in IDLE
//  start_addr  in   ADDR_W   first RAM address of the run
//  word_count  in   ADDR_W+1 number of words to sum (0..127)
//  ram_addr    out  ADDR_W   to RAM addr; RAM returns data one cycle after addr is presented
//  ram_data    in   DATA_W   from RAM data_out
//  busy        out  1        high from the cycle after start is accepted until done
//  done        out  1        one-cycle pulse; sum valid
//  sum         out  ACC_W    run total; held stable from done until the next accepted start
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge) applies in any state and aborts a run in progress:
//    state=IDLE, ram_addr=0, busy=0, done=0, sum=0, all valid bits cleared, no done pulse.
//  - FSM states IDLE, ISSUE, DRAIN, DONE.
//    - IDLE & start & word_count!=0 -> ISSUE.
//      Load addr=start_addr, remaining=word_count, clear acc.
//    - IDLE & start & word_count==0 -> DONE. Clear acc, so sum=0.
//    - ISSUE: present ram_addr each cycle, set v1 for the next cycle,
//      addr<=addr+1 mod 64 (63 wraps to 0), remaining--.
//      Leave to DRAIN after the cycle that presents the last address.
//    - DRAIN: stay until v1 and v2 are both 0 and the last add has completed.
//    - DRAIN -> DONE.
//    - DONE: done=1 for exactly one cycle, then -> IDLE.
//  - Datapath pipeline:
//    - Cycle t: address presented.
//    - Cycle t+1: ram_data valid (v1); combinational 16-lane tree sum registered at end of t+1
//      into tree_q (LANE_W+4 bits), with v2.
//    - When v2=1: acc <= acc + zero-extended tree_q.
//  - Latency: with start sampled in cycle 0 and N>=1, addresses occupy cycles 1..N.
//    done is high in cycle N+3. With N=0, done is high in cycle 1.
//  - Throughput: one word per cycle; no stalls; ram_addr advances every ISSUE cycle.
//  - start is ignored outside IDLE; it is not queued.
//  - ram_addr holds its last value while IDLE, DRAIN and DONE.
//  - word_count>64 is legal; addresses wrap and words are re-read.
//  - Arithmetic: lanes unsigned. Max total 127*16*(2^32-1) < 2^43, so ACC_W=48 never overflows.
//    No saturation or overflow flag.
//  - sum is driven directly from acc; it shows partial values only while busy.
// STRUCTURE
//  - Shared package acc_pkg: DATA_W/ADDR_W/LANE_W/LANES/ACC_W constants and the FSM state
//    encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3).
//  - One sub-module: lane_adder_tree (combinational, DATA_W in, LANE_W+$clog2(LANES) out),
//    so the same tree can be reused by the other parallel-adder stages.
//  - FSM, address counter, valid pipe and accumulator stay in this module.
// TESTING (bench models the RAM with 1-cycle registered-address read)
//  1. Hold rst_n=0 2 cycles -> busy=0, done=0, sum=0, ram_addr=0. Pulse start during reset
//     -> no activity after release.
//  2. RAM word k has all lanes = k; start_addr=0, word_count=4 -> ram_addr 0,1,2,3 in
//     cycles 1-4; done in cycle 7; sum=96.
//  3. Same RAM; start_addr=62, word_count=4 -> addresses 62,63,0,1; sum=2016.
//  4. All lanes 0xFFFFFFFF; start_addr=5, word_count=64 -> done in cycle 67;
//     sum=0x3FF_FFFF_FC00.
//  5. word_count=0 -> done in cycle 1, sum=0, ram_addr unchanged.
//  6. Start a 10-word run. Pulse start again in cycle 3 -> ignored, single done.
//     Then start a new run and drop rst_n in cycle 5 -> no done, sum=0, IDLE.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared constants and FSM encoding for the RAM word accumulator and its adder tree.
package acc_pkg;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 6;
  localparam int LANE_W = 32;
  localparam int LANES  = DATA_W / LANE_W;
  localparam int ACC_W  = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational binary adder tree over the unsigned lanes of one word.
// Zero latency; LANES must be a power of two; no flow control.
module lane_adder_tree #(
  parameter int DATA_W = 512,
  parameter int LANE_W = 32,
  parameter int LANES  = DATA_W / LANE_W,
  parameter int OUT_W  = LANE_W + $clog2(LANES)
) (
  input  logic [DATA_W-1:0] data,
  output logic [OUT_W-1:0]  sum
);

  localparam int LVLS = $clog2(LANES);

  // Level g holds LANES>>g partial sums; each level pairs up the one below it.
  for (genvar g = 0; g <= LVLS; g++) begin : lv
    logic [OUT_W-1:0] s [LANES >> g];
    for (genvar i = 0; i < (LANES >> g); i++) begin : node
      if (g == 0) begin : leaf
        assign s[i] = {{(OUT_W - LANE_W){1'b0}}, data[i*LANE_W +: LANE_W]};
      end else begin : add
        assign s[i] = lv[g-1].s[2*i] + lv[g-1].s[2*i+1];
      end
    end
  end

  assign sum = lv[LVLS].s[0];

endmodule

// File: rtl/ram_word_accumulator.sv
// Sequences RAM reads over a run of words and accumulates the lane sums into one total.
// Done arrives N+3 cycles after start (1 for N=0); one word per cycle, never stalls.
module ram_word_accumulator
  import acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sum
);

  localparam int TREE_W = LANE_W + $clog2(LANES);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              v1, v2;
  logic [TREE_W-1:0] tree_d, tree_q;
  logic [ACC_W-1:0]  acc;

  lane_adder_tree #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .LANES  (LANES),
    .OUT_W  (TREE_W)
  ) u_tree (
    .data (ram_data),
    .sum  (tree_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DRAIN may exit once v1 is clear: the add for v2 completes on this same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (word_count != '0) ? ISSUE : DONE;
      ISSUE:   if (remaining == (ADDR_W+1)'(1)) state_nxt = DRAIN;
      DRAIN:   if (!v1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ISSUE, DRAIN: busy = 1'b1;
      DONE:         done = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      tree_q    <= '0;
      acc       <= '0;
    end else begin
      v1     <= (state == ISSUE);
      v2     <= v1;
      tree_q <= tree_d;
      if (v2) acc <= acc + {{(ACC_W - TREE_W){1'b0}}, tree_q};
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            if (word_count != '0) begin
              addr      <= start_addr;
              remaining <= word_count;
            end
          end
        end
        ISSUE: begin
          remaining <= remaining - 1'b1;
          // Keep the last presented address on the bus after the run.
          if (remaining != (ADDR_W+1)'(1)) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr = addr;
  assign sum      = acc;

endmodule

// File: tb/tb_ram_word_accumulator.sv
// Randomized and directed bench with a 1-cycle registered-read RAM and an arithmetic sum model.
module tb_ram_word_accumulator;
  import acc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  sum;

  logic [DATA_W-1:0] mem [64];
  int checks = 0;
  int errors = 0;

  ram_word_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .busy       (busy),
    .done       (done),
    .sum        (sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned model_sum(input int sa, input int n);
    longint unsigned s = 0;
    for (int k = 0; k < n; k++)
      for (int l = 0; l < LANES; l++)
        s += longint'(mem[(sa + k) % 64][l*LANE_W +: LANE_W]);
    return s;
  endfunction

  task automatic fill_index();
    for (int k = 0; k < 64; k++)
      for (int l = 0; l < LANES; l++) mem[k][l*LANE_W +: LANE_W] = 32'(k);
  endtask

  task automatic fill_ones();
    for (int k = 0; k < 64; k++) mem[k] = '1;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 64; k++)
      for (int l = 0; l < LANES; l++) mem[k][l*LANE_W +: LANE_W] = $urandom;
  endtask

  // Runs one job started in cycle 0; optionally pulses start again in cycle pulse_cyc.
  task automatic run(input string tag, input int sa, input int n, input int pulse_cyc);
    int done_cyc = -1;
    int extra_done = 0;
    int sum_moved = 0;
    int busy_after = 0;
    longint unsigned exp_sum;
    logic [ADDR_W-1:0] prev_addr;
    logic [ACC_W-1:0] held;
    exp_sum = model_sum(sa, n);
    @(negedge clk);
    prev_addr  = ram_addr;
    start      = 1'b1;
    start_addr = ADDR_W'(sa);
    word_count = (ADDR_W+1)'(n);
    @(negedge clk);
    for (int c = 1; c < 200; c++) begin
      if (c == pulse_cyc) begin
        start      = 1'b1;
        start_addr = ADDR_W'(sa + 7);
        word_count = (ADDR_W+1)'(3);
      end else begin
        start = 1'b0;
      end
      if (c <= n) chk({tag, " addr"}, 64'(ram_addr), 64'((sa + c - 1) % 64));
      if (c == 1 && n > 0) chk({tag, " busy"}, 64'(busy), 64'd1);
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, 64'(done_cyc), 64'((n == 0) ? 1 : n + 3));
    chk({tag, " sum"}, 64'(sum), exp_sum);
    if (n == 0) chk({tag, " addr_hold"}, 64'(ram_addr), 64'(prev_addr));
    else        chk({tag, " addr_hold"}, 64'(ram_addr), 64'((sa + n - 1) % 64));
    held = sum;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) busy_after++;
      if (sum !== held) sum_moved++;
    end
    chk({tag, " extra_done"}, 64'(extra_done), 64'd0);
    chk({tag, " busy_after"}, 64'(busy_after), 64'd0);
    chk({tag, " sum_held"}, 64'(sum_moved), 64'd0);
  endtask

  initial begin
    int act;
    rst_n      = 1'b0;
    start      = 1'b1;
    start_addr = 6'd9;
    word_count = 7'd4;
    fill_index();
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset sum", 64'(sum), 64'd0);
    chk("reset addr", 64'(ram_addr), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    act = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy || done || ram_addr != 0) act++;
    end
    chk("post_reset activity", 64'(act), 64'd0);

    run("idx0", 0, 4, 0);
    chk("idx0 const", 64'(sum), 64'd96);
    run("idxwrap", 62, 4, 0);
    chk("idxwrap const", 64'(sum), 64'd2016);

    fill_ones();
    run("ones64", 5, 64, 0);
    chk("ones64 const", 64'(sum), 64'h3FF_FFFF_FC00);

    fill_rand();
    run("zero", 17, 0, 0);
    chk("zero const", 64'(sum), 64'd0);
    run("ignore", 20, 10, 3);
    for (int i = 0; i < 6; i++) begin
      int sa;
      int n;
      sa = $urandom_range(63, 0);
      n  = $urandom_range(127, 0);
      run($sformatf("rand%0d", i), sa, n, 0);
    end
    run("max", 40, 127, 0);

    // Abort a run with reset in cycle 5.
    @(negedge clk);
    start      = 1'b1;
    start_addr = 6'd3;
    word_count = 7'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort sum", 64'(sum), 64'd0);
    chk("abort addr", 64'(ram_addr), 64'd0);
    act = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy || done || sum != 0) act++;
    end
    chk("abort quiet", 64'(act), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
